ser_ch_scheduler: RTL

//  Round-robin scheduler sharing the single 8-channel 16x-rate serializer among 8 frame requesters.

---
 rtl/ser_sched_pkg.sv | 42 ++++
 rtl/ser_ch_scheduler_rr_arbiter.sv | 56 +++++
 rtl/ser_ch_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ser_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ser_sched_pkg
// Purpose : Shared types, sizes and helpers for the serializer channel
//           scheduler (state encoding, one-hot and length-check functions).
// Rev     : 1.0  initial release
// ============================================================================
package ser_sched_pkg;

  localparam int NCH = 8;                 // requesters / serializer channels
  localparam int DW  = 128;               // payload width, also max length
  localparam int CW  = 16;                // length / count width
  localparam int CHW = $clog2(NCH);       // channel index width

  // Scheduler states with fixed 2-bit encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    GAP   = 2'd3
  } sched_state_e;

  // Channel index to one-hot strobe
  function automatic logic [NCH-1:0] onehot(input logic [CHW-1:0] idx);
    logic [NCH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Length is unusable as given: empty or longer than the payload
  function automatic logic len_bad(input logic [CW-1:0] len);
    return (len == '0) || (len > CW'(DW));
  endfunction

  // Oversized lengths are trimmed to the full payload
  function automatic logic [CW-1:0] len_clamp(input logic [CW-1:0] len);
    return (len > CW'(DW)) ? CW'(DW) : len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ser_ch_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Round-robin arbiter. Grants the lowest requesting index at or
//           above the rotation pointer (wrapping); the pointer moves past
//           the winner whenever a grant is issued.
// Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NCH = 8
) (
  input  logic                    clk_out16x,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NCH-1:0]          req,
  output logic [NCH-1:0]          grant,
  output logic [$clog2(NCH)-1:0]  grant_idx
);

  localparam int PW = $clog2(NCH);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic          w_found;

  // Search from the pointer upward, wrapping, for the first active request
  always_comb begin
    grant     = '0;
    grant_idx = r_ptr;
    w_found   = 1'b0;
    w_idx     = '0;
    if (en) begin
      for (int k = 0; k < NCH; k++) begin
        w_idx = PW'((int'(r_ptr) + k) % NCH);
        if (!w_found && req[w_idx]) begin
          w_found   = 1'b1;
          grant_idx = w_idx;
        end
      end
    end
    if (w_found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // A grant is always taken (request is known high), so advance past it
  always_ff @(posedge clk_out16x or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (|grant) begin
      r_ptr <= (grant_idx == PW'(NCH - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ser_ch_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : ser_ch_scheduler
// Purpose : Shares one 8-channel serializer among 8 frame requesters using
//           round-robin arbitration. Latches the granted payload/length,
//           strobes the channel for one cycle, then tracks the serializer's
//           crc_valid window for exactly len cycles before the next grant.
// Config  : GAP_INSERT_EN - when defined, GAP_CYCLES idle cycles (busy high,
//           no grants) follow every completed frame.
// Rev     : 1.0  initial release
// ============================================================================
module ser_ch_scheduler
  import ser_sched_pkg::*;
`ifdef GAP_INSERT_EN
  #(parameter int unsigned GAP_CYCLES = 2)
`endif
(
  input  logic              clk_out16x,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req_vld,
  output logic [NCH-1:0]    req_rdy,
  input  logic [NCH*DW-1:0] req_data,
  input  logic [NCH*CW-1:0] req_len,
  output logic [DW-1:0]     data_gray,
  output logic [NCH-1:0]    vld_ch,
  output logic [CW-1:0]     data_count,
  input  logic              crc_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              err_len,
  output logic              err_proto
);

  sched_state_e   r_state;
  sched_state_e   w_state_nxt;
  logic [CW-1:0]  r_run_cnt;
  logic [CW-1:0]  w_run_cnt_nxt;
  logic [NCH-1:0] w_grant;
  logic [CHW-1:0] w_gidx;
  logic [CW-1:0]  w_len_sel;
  logic [DW-1:0]  w_data_sel;
  logic           w_accept;
  logic           w_start;
  logic           w_proto_err;
`ifdef GAP_INSERT_EN
  logic [CW-1:0]  r_gap_cnt;
  logic [CW-1:0]  w_gap_cnt_nxt;
`endif

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk_out16x (clk_out16x),
    .rst_n      (rst_n),
    .en         (r_state == IDLE),
    .req        (req_vld),
    .grant      (w_grant),
    .grant_idx  (w_gidx)
  );

  assign req_rdy  = w_grant;
  assign w_accept = |w_grant;
  // Zero-length frames are accepted but dropped without starting a frame
  assign w_start  = w_accept && (w_len_sel != '0);

  // Select the granted requester's payload and length
  always_comb begin
    w_len_sel  = '0;
    w_data_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_gidx == CHW'(k)) begin
        w_len_sel  = req_len[k*CW +: CW];
        w_data_sel = req_data[k*DW +: DW];
      end
    end
  end

  // Next-state, run counter and protocol checking against crc_valid
  always_comb begin
    w_state_nxt   = r_state;
    w_run_cnt_nxt = r_run_cnt;
    w_proto_err   = 1'b0;
`ifdef GAP_INSERT_EN
    w_gap_cnt_nxt = r_gap_cnt;
`endif
    case (r_state)
      IDLE: begin
        w_proto_err = crc_valid;
        if (w_start) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_proto_err   = crc_valid;
        w_state_nxt   = RUN;
        w_run_cnt_nxt = data_count;
      end
      RUN: begin
        if (!crc_valid) begin
          // Serializer stopped early: abort without any trailing gap
          w_proto_err = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_run_cnt_nxt = r_run_cnt - CW'(1);
          if (r_run_cnt == CW'(1)) begin
`ifdef GAP_INSERT_EN
            if (GAP_CYCLES == 0) begin
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt   = GAP;
              w_gap_cnt_nxt = CW'(GAP_CYCLES - 1);
            end
`else
            w_state_nxt = IDLE;
`endif
          end
        end
      end
      GAP: begin
`ifdef GAP_INSERT_EN
        if (r_gap_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - CW'(1);
        end
`else
        w_state_nxt = IDLE;
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered serializer-side outputs; payload only moves on accept
  always_ff @(posedge clk_out16x or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_run_cnt  <= '0;
      vld_ch     <= '0;
      data_gray  <= '0;
      data_count <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_len    <= 1'b0;
      err_proto  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_run_cnt  <= w_run_cnt_nxt;
      vld_ch     <= w_start ? onehot(w_gidx) : '0;
      if (w_start) begin
        data_gray  <= w_data_sel;
        data_count <= len_clamp(w_len_sel);
      end
      busy       <= (w_state_nxt != IDLE);
      frame_done <= (w_state_nxt == RUN) && (w_run_cnt_nxt == CW'(1));
      err_len    <= w_accept && len_bad(w_len_sel);
      err_proto  <= w_proto_err;
    end
  end

`ifdef GAP_INSERT_EN
  // Post-frame idle counter
  always_ff @(posedge clk_out16x or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_cnt <= '0;
    end else begin
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end
`endif

endmodule
`default_nettype wire
